// File: rtl/sub_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // Bit-counter width; never below one bit so the counter always exists.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit combinational subtractor slice: d = a - b - bin, with borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor (diff = a - b), LSB first, one bit per cycle,
// with valid/ready handshakes on both operand and result sides.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int unsigned CNTW = cnt_width(WIDTH);

  state_t           r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_r;
  logic             r_br;
  logic [CNTW-1:0]  r_cnt;
  logic             r_a_msb;
  logic             r_b_msb;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_ovf;

  logic             w_d;
  logic             w_bn;
  logic [WIDTH-1:0] w_r_next;

  full_subtractor u_slice (
    .a    (r_sa[0]),
    .b    (r_sb[0]),
    .bin  (r_br),
    .d    (w_d),
    .bout (w_bn)
  );

  // Result bits arrive LSB first, so they enter at the MSB and walk down.
  assign w_r_next = {w_d, r_r[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_sa    <= '0;
      r_sb    <= '0;
      r_r     <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sa    <= a;
            r_sb    <= b;
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          r_sa  <= {1'b0, r_sa[WIDTH-1:1]};
          r_sb  <= {1'b0, r_sb[WIDTH-1:1]};
          r_r   <= w_r_next;
          r_br  <= w_bn;
          r_cnt <= r_cnt + CNTW'(1);
          // Last slice: its output bit is the result MSB used for overflow.
          if (r_cnt == CNTW'(WIDTH - 1)) begin
            r_diff  <= w_r_next;
            r_bout  <= w_bn;
            r_ovf   <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
            r_state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign diff      = r_diff;
  assign bout      = r_bout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor at WIDTH=8.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;

  int n_vec;
  int n_err;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_vec++;
    assert (observed === expected)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Accept one operand pair, then wait (bounded) for out_valid and check latency and result.
  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] exp_d, input logic exp_bo, input logic exp_ov);
    int cyc;
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    a = av;
    b = bv;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = '0;
    b = '0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'd8);
    check({tag, "_diff"}, 64'(diff), 64'(exp_d));
    check({tag, "_bout"}, 64'(bout), 64'(exp_bo));
    check({tag, "_ovf"}, 64'(ovf), 64'(exp_ov));
  endtask

  initial begin
    logic [W-1:0] q_a[$];
    logic [W-1:0] q_b[$];
    logic [W-1:0] ea, eb, ed;
    logic         eov, ebo;
    int           done_ops, cyc, last_ov, seen;

    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_diff", 64'(diff), 64'd0);
    check("rst_flags", 64'({bout, ovf}), 64'd0);
    tick();
    tick();
    rst = 1'b0;

    run_op("op200_55", 8'd200, 8'd55, 8'h91, 1'b0, 1'b0);
    tick();
    check("op200_55_retire", 64'({out_valid, in_ready}), 64'b01);
    run_op("op5_9", 8'd5, 8'd9, 8'hFC, 1'b1, 1'b0);
    tick();
    run_op("op0_0", 8'd0, 8'd0, 8'h00, 1'b0, 1'b0);
    tick();
    run_op("op80_01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    tick();
    run_op("op7f_ff", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
    tick();

    // Back-pressure: result held for 5 cycles while new operands are offered.
    out_ready = 1'b0;
    run_op("bp", 8'd100, 8'd30, 8'h46, 1'b0, 1'b0);
    a = 8'd1;
    b = 8'd2;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_valid", 64'({out_valid, in_ready}), 64'b10);
      check("bp_hold_result", 64'({diff, bout, ovf}), 64'({8'h46, 2'b00}));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_retire", 64'({out_valid, in_ready}), 64'b01);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("bp_single_retire", 64'(seen), 64'd0);
    check("bp_diff_kept", 64'(diff), 64'h46);

    // Reset during the third BUSY cycle discards the operation.
    a = 8'd50;
    b = 8'd20;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("mid_rst_ready", 64'({out_valid, in_ready}), 64'b01);
    check("mid_rst_outs", 64'({diff, bout, ovf}), 64'd0);
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("mid_rst_no_valid", 64'(seen), 64'd0);
    run_op("op10_3", 8'd10, 8'd3, 8'h07, 1'b0, 1'b0);
    tick();

    // Back-to-back random operations against a parallel reference.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    a = W'($urandom);
    b = W'($urandom);
    done_ops = 0;
    cyc = 0;
    last_ov = -1;
    while (done_ops < 1000 && cyc < 15000) begin
      if (in_ready) begin
        q_a.push_back(a);
        q_b.push_back(b);
      end
      tick();
      cyc++;
      if (out_valid) begin
        if (q_a.size() == 0) begin
          check("b2b_unexpected_valid", 64'd1, 64'd0);
        end else begin
          ea  = q_a.pop_front();
          eb  = q_b.pop_front();
          ed  = ea - eb;
          ebo = (ea < eb);
          eov = (ea[W-1] != eb[W-1]) && (ed[W-1] != ea[W-1]);
          check("b2b_result", 64'({diff, bout, ovf}), 64'({ed, ebo, eov}));
        end
        if (last_ov >= 0) check("b2b_interval", 64'(cyc - last_ov), 64'd10);
        last_ov = cyc;
        done_ops++;
      end
      a = W'($urandom);
      b = W'($urandom);
    end
    check("b2b_op_count", 64'(done_ops), 64'd1000);
    in_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor computing `diff = a - b` over WIDTH cycles, LSB first, with one borrow flip-flop carried between bit slices. It is the subtraction counterpart to the team's ripple adder and targets area-constrained datapaths where a WIDTH-bit parallel subtractor is too large. Operands enter through a valid/ready handshake, and the result leaves through a second valid/ready handshake. Each result comes with an unsigned borrow flag and a signed-overflow flag.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range 2..64.
- `clk` input 1: rising-edge clock; the only clock in the block.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: operands `a`/`b` are valid.
- `in_ready` output 1: block can accept operands; high only in IDLE.
- `a` input WIDTH: minuend.
- `b` input WIDTH: subtrahend.
- `out_valid` output 1: result is valid; high only in DONE.
- `out_ready` input 1: consumer accepts the result.
- `diff` output WIDTH: `a - b` modulo 2^WIDTH.
- `bout` output 1: final borrow; 1 iff `a < b` unsigned.
- `ovf` output 1: signed overflow of `a - b`.

## Operation
- FSM states:
  - IDLE: `in_ready=1`.
  - BUSY: shifting.
  - DONE: `out_valid=1`, result held.
- IDLE→BUSY on `in_valid && in_ready` at a rising edge. On that edge:
  - latch `a` into shift register SA and `b` into SB;
  - latch `a[WIDTH-1]` and `b[WIDTH-1]` into sign registers;
  - clear borrow register BR and bit counter CNT.
- Each BUSY edge processes bit slice SA[0], SB[0], BR:
  - `d = SA[0]^SB[0]^BR`
  - `bn = (~SA[0]&SB[0]) | (~(SA[0]^SB[0])&BR)`
  - SA and SB shift right by 1.
  - `d` shifts into the MSB of the result register R, which shifts right.
  - BR ← `bn`; CNT ← CNT+1.
- BUSY→DONE on the edge where CNT reaches WIDTH-1, i.e. after exactly WIDTH BUSY edges. On entering DONE:
  - `bout` = final BR;
  - `ovf` = `(a_msb != b_msb) && (R[WIDTH-1] != a_msb)`.
- DONE→IDLE on `out_valid && out_ready`.
- `diff`, `bout` and `ovf` are registered. They are stable for the whole DONE period, and keep their last values in IDLE and BUSY.
- `in_valid` is ignored outside IDLE, and `a`/`b` are don't-care outside the accept edge.
- `out_ready` is ignored outside DONE.
- Operands are not re-sampled during BUSY, so upstream may change `a`/`b` freely after acceptance.

## Timing
- Reset: state=IDLE, `in_ready=1`, `out_valid=0`, `diff=0`, `bout=0`, `ovf=0`, and SA, SB, R, BR, CNT all 0.
- Latency: with accept at edge E0, `out_valid` rises after edge E_WIDTH.
- Minimum initiation interval, with `out_ready` tied high: WIDTH+2 cycles.
  - DONE lasts one cycle.
  - IDLE lasts one cycle before the next accept.
- Back-pressure: DONE is held indefinitely while `out_ready=0`. `in_ready` stays 0 throughout.
- Reset asserted in BUSY or DONE: the block returns to IDLE immediately (asynchronous). The partial or pending result is discarded and no `out_valid` pulse is produced.
- Reset deassertion is synchronised externally. The first accept is possible on the first edge after release.
- Combinational paths: none from inputs to outputs. `in_ready` and `out_valid` decode directly from state flops.

## Structure
- Shared package `sub_pkg`:
  - state encoding `IDLE=2'd0`, `BUSY=2'd1`, `DONE=2'd2`; the unused code 2'd3 recovers to IDLE;
  - counter-width constant `CNTW = clog2(WIDTH)`.
- Sub-module `full_subtractor`: combinational 1-bit slice with ports `a`, `b`, `bin`, `d`, `bout`. It is instantiated once in BUSY datapath logic.
- Everything else (FSM, shift registers, counter, flag generation) lives in `serial_subtractor`.

## Test plan
- WIDTH=8, a=200, b=55, out_ready=1: `diff=0x91`, `bout=0`, `ovf=0`. `out_valid` rises 8 cycles after the accept edge.
- a=5, b=9: `diff=0xFC`, `bout=1`, `ovf=0`. Also a=0, b=0: `diff=0x00`, `bout=0`, `ovf=0`.
- a=0x80, b=0x01: `diff=0x7F`, `bout=0`, `ovf=1`. Also a=0x7F, b=0xFF: `diff=0x80`, `bout=1`, `ovf=1`.
- Back-pressure: hold `out_ready=0` for 5 cycles in DONE.
  - `diff`, `bout` and `ovf` stay constant, and `in_ready=0` for the whole period.
  - `in_valid` pulses with new operands are ignored.
  - After `out_ready=1`, the original result retires once.
- Assert `rst` mid-BUSY, at the 3rd BUSY cycle: all outputs go to 0 and `in_ready=1` at once, with no `out_valid`. A fresh a=10, b=3 then yields `diff=0x07`.
- Back-to-back operations, with `in_valid` and `out_ready` tied high and random operands over 1000 ops:
  - results match a reference model;
  - consecutive `out_valid` pulses are exactly 10 cycles apart.
